// File: rtl/jump_target_unit.sv
`default_nettype none
// ============================================================================
// Module      : jump_target_unit
// Description : Registered jump/branch target generator for the ID stage.
//               Four modes (J, JAL, BRANCH, JR) produce a target address one
//               cycle after an accepted request. A circular return-address
//               stack (RAS) records JAL link addresses; JR returns compare
//               their register operand against the RAS top and pop it.
//
// Ports       : i_clock        rising-edge clock
//               i_reset        asynchronous, active-low reset
//               i_enable       0 = stall: outputs and RAS hold
//               i_flush        discard the current request (beats i_enable)
//               i_valid        request present
//               i_mode         00 J, 01 JAL, 10 BRANCH, 11 JR
//               i_is_ret       JR is a return through $31
//               i_inst         instruction index / branch offset field
//               i_next_pc      PC+4 of the jump/branch
//               i_rs_data      register operand for JR
//               o_target       computed target
//               o_link         link address (JAL only)
//               o_valid        o_target/o_link valid
//               o_pred_target  RAS top seen by a JR-return (0 if empty)
//               o_pred_hit     JR-return whose RAS top matched i_rs_data
//               o_ras_count    live RAS entries
//
// Revision    : 1.0 - initial release
// ============================================================================
module jump_target_unit #(
  parameter int NB_PC         = 32,
  parameter int NB_ADDR       = 26,
  parameter int NB_UPPER_PC   = 4,
  parameter int NB_LOWER_BITS = 2,
  parameter int NB_IMM        = 16,
  parameter int RAS_DEPTH     = 4
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic                             i_enable,
  input  logic                             i_flush,
  input  logic                             i_valid,
  input  logic [1:0]                       i_mode,
  input  logic                             i_is_ret,
  input  logic [NB_ADDR-1:0]               i_inst,
  input  logic [NB_PC-1:0]                 i_next_pc,
  input  logic [NB_PC-1:0]                 i_rs_data,
  output logic [NB_PC-1:0]                 o_target,
  output logic [NB_PC-1:0]                 o_link,
  output logic                             o_valid,
  output logic [NB_PC-1:0]                 o_pred_target,
  output logic                             o_pred_hit,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   o_ras_count
);

  localparam int c_NB_PTR = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int c_NB_CNT = $clog2(RAS_DEPTH + 1);

  localparam logic [c_NB_PTR-1:0] c_LAST_PTR  = c_NB_PTR'(RAS_DEPTH - 1);
  localparam logic [c_NB_CNT-1:0] c_FULL_CNT  = c_NB_CNT'(RAS_DEPTH);

  localparam logic [1:0] c_MODE_J      = 2'b00;
  localparam logic [1:0] c_MODE_JAL    = 2'b01;
  localparam logic [1:0] c_MODE_BRANCH = 2'b10;
  localparam logic [1:0] c_MODE_JR     = 2'b11;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [NB_PC-1:0]    r_ras [RAS_DEPTH];
  // r_wr_ptr is the slot the next push lands in; the top is the slot before
  // it. When the stack is full, r_wr_ptr already points at the oldest entry,
  // so a push naturally overwrites it.
  logic [c_NB_PTR-1:0] r_wr_ptr;
  logic [c_NB_CNT-1:0] r_count;

  logic [NB_PC-1:0]    r_target;
  logic [NB_PC-1:0]    r_link;
  logic                r_valid;
  logic [NB_PC-1:0]    r_pred_target;
  logic                r_pred_hit;

  // --------------------------------------------------------------------------
  // Combinational target generation and RAS control
  // --------------------------------------------------------------------------
  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic                w_ras_empty;
  logic [c_NB_PTR-1:0] w_top_ptr;
  logic [c_NB_PTR-1:0] w_next_wr_ptr;
  logic [NB_PC-1:0]    w_ras_top;
  logic [NB_PC-1:0]    w_jump_target;
  logic [NB_PC-1:0]    w_imm_ext;
  logic [NB_PC-1:0]    w_branch_target;
  logic [NB_PC-1:0]    w_jr_target;
  logic [NB_PC-1:0]    w_target;

  assign w_accept    = i_valid & i_enable & ~i_flush;
  assign w_push      = w_accept & (i_mode == c_MODE_JAL);
  assign w_pop       = w_accept & (i_mode == c_MODE_JR) & i_is_ret;
  assign w_ras_empty = (r_count == '0);

  // Explicit wrap so non-power-of-two depths index correctly.
  assign w_top_ptr     = (r_wr_ptr == '0)         ? c_LAST_PTR : r_wr_ptr - c_NB_PTR'(1);
  assign w_next_wr_ptr = (r_wr_ptr == c_LAST_PTR) ? '0         : r_wr_ptr + c_NB_PTR'(1);
  assign w_ras_top     = r_ras[w_top_ptr];

  assign w_jump_target   = {i_next_pc[NB_PC-1 -: NB_UPPER_PC], i_inst, {NB_LOWER_BITS{1'b0}}};
  assign w_imm_ext       = {{(NB_PC-NB_IMM){i_inst[NB_IMM-1]}}, i_inst[NB_IMM-1:0]};
  assign w_branch_target = i_next_pc + (w_imm_ext << NB_LOWER_BITS);
  assign w_jr_target     = {i_rs_data[NB_PC-1:NB_LOWER_BITS], {NB_LOWER_BITS{1'b0}}};

  always_comb begin
    w_target = '0;
    case (i_mode)
      c_MODE_J, c_MODE_JAL: w_target = w_jump_target;
      c_MODE_BRANCH:        w_target = w_branch_target;
      c_MODE_JR:            w_target = w_jr_target;
      default:              w_target = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Return-address stack
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_ras[i] <= '0;
      end
    end else if (w_push) begin
      r_ras[r_wr_ptr] <= i_next_pc;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_push) begin
      r_wr_ptr <= w_next_wr_ptr;
      if (r_count != c_FULL_CNT) begin
        r_count <= r_count + c_NB_CNT'(1);
      end
    end else if (w_pop && !w_ras_empty) begin
      r_wr_ptr <= w_top_ptr;
      r_count  <= r_count - c_NB_CNT'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_target      <= '0;
      r_link        <= '0;
      r_valid       <= 1'b0;
      r_pred_target <= '0;
      r_pred_hit    <= 1'b0;
    end else if (i_flush) begin
      // Kill the request; address outputs keep their last value.
      r_valid    <= 1'b0;
      r_pred_hit <= 1'b0;
    end else if (i_enable) begin
      if (i_valid) begin
        r_target <= w_target;
        r_link   <= (i_mode == c_MODE_JAL) ? i_next_pc : '0;
        r_valid  <= 1'b1;
        if (w_pop && !w_ras_empty) begin
          r_pred_target <= w_ras_top;
          r_pred_hit    <= (w_ras_top == i_rs_data);
        end else begin
          r_pred_target <= '0;
          r_pred_hit    <= 1'b0;
        end
      end else begin
        r_target      <= '0;
        r_link        <= '0;
        r_valid       <= 1'b0;
        r_pred_target <= '0;
        r_pred_hit    <= 1'b0;
      end
    end
  end

  assign o_target      = r_target;
  assign o_link        = r_link;
  assign o_valid       = r_valid;
  assign o_pred_target = r_pred_target;
  assign o_pred_hit    = r_pred_hit;
  assign o_ras_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_jump_target_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_jump_target_unit
// Description : Directed self-checking bench for jump_target_unit. A
//               queue-based reference model is compared against the DUT on
//               every clock edge; directed steps add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jump_target_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, fl, v, ret;
  logic [1:0]  mode;
  logic [25:0] inst;
  logic [31:0] npc, rs;

  logic [31:0] o_target, o_link, o_pred_target;
  logic        o_valid, o_pred_hit;
  logic [2:0]  o_ras_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jump_target_unit dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_enable      (en),
    .i_flush       (fl),
    .i_valid       (v),
    .i_mode        (mode),
    .i_is_ret      (ret),
    .i_inst        (inst),
    .i_next_pc     (npc),
    .i_rs_data     (rs),
    .o_target      (o_target),
    .o_link        (o_link),
    .o_valid       (o_valid),
    .o_pred_target (o_pred_target),
    .o_pred_hit    (o_pred_hit),
    .o_ras_count   (o_ras_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: stack kept as a queue, outputs from the address rules.
  // --------------------------------------------------------------------------
  logic [31:0] m_target = '0, m_link = '0, m_pred = '0;
  logic        m_valid = 1'b0, m_hit = 1'b0;
  logic [31:0] m_stack[$];
  int          m_off;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_target = '0; m_link = '0; m_pred = '0; m_valid = 1'b0; m_hit = 1'b0;
      m_stack.delete();
    end else if (fl) begin
      m_valid = 1'b0;
      m_hit   = 1'b0;
    end else if (en) begin
      m_pred = '0; m_hit = 1'b0; m_link = '0; m_target = '0;
      m_valid = v;
      if (v) begin
        case (mode)
          2'd0: m_target = {npc[31:28], inst, 2'b00};
          2'd1: begin
            m_target = {npc[31:28], inst, 2'b00};
            m_link   = npc;
            m_stack.push_back(npc);
            if (m_stack.size() > 4) void'(m_stack.pop_front());
          end
          2'd2: begin
            m_off    = $signed(inst[15:0]);
            m_target = npc + 32'(m_off * 4);
          end
          default: begin
            m_target = rs & 32'hFFFF_FFFC;
            if (ret && m_stack.size() > 0) begin
              m_pred = m_stack.pop_back();
              m_hit  = (m_pred == rs);
            end
          end
        endcase
      end
    end
    #1;
    chk("model_target",    o_target,                m_target);
    chk("model_link",      o_link,                  m_link);
    chk("model_valid",     32'(o_valid),            32'(m_valid));
    chk("model_pred",      o_pred_target,           m_pred);
    chk("model_hit",       32'(o_pred_hit),         32'(m_hit));
    chk("model_count",     32'(o_ras_count),        32'(m_stack.size()));
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers: inputs change on the falling edge, checks at +2 after
  // the rising edge.
  // --------------------------------------------------------------------------
  task automatic drive(input logic e, input logic f, input logic vv, input logic [1:0] m,
                       input logic r, input logic [25:0] in, input logic [31:0] pc,
                       input logic [31:0] rsd);
    @(negedge clk);
    en = e; fl = f; v = vv; mode = m; ret = r; inst = in; npc = pc; rs = rsd;
  endtask

  task automatic req(input logic [1:0] m, input logic r, input logic [25:0] in,
                     input logic [31:0] pc, input logic [31:0] rsd);
    drive(1'b1, 1'b0, 1'b1, m, r, in, pc, rsd);
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, '0, '0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; fl = 1'b0; v = 1'b0; mode = 2'd0; ret = 1'b0;
    inst = '0; npc = '0; rs = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_valid",  32'(o_valid),     32'd0);
    chk("reset_count",  32'(o_ras_count), 32'd0);
    chk("reset_target", o_target,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // J
    req(2'd0, 1'b0, 26'h100, 32'h4000_0010, 32'h0); step();
    chk("j_target", o_target, 32'h4000_0400);
    chk("j_valid",  32'(o_valid), 32'd1);
    chk("j_link",   o_link, 32'd0);
    idle(); step();
    chk("j_valid_drop", 32'(o_valid), 32'd0);

    // BRANCH
    req(2'd2, 1'b0, 26'h0FFFE, 32'h0000_0100, 32'h0); step();
    chk("br_neg", o_target, 32'h0000_00F8);
    req(2'd2, 1'b0, 26'h00004, 32'h0000_0100, 32'h0); step();
    chk("br_pos", o_target, 32'h0000_0110);
    req(2'd2, 1'b0, 26'h00001, 32'hFFFF_FFFC, 32'h0); step();
    chk("br_wrap", o_target, 32'h0000_0000);

    // JAL then matching / mismatching returns
    req(2'd1, 1'b0, 26'h0, 32'h100, 32'h0); step();
    chk("jal_link",  o_link, 32'h100);
    chk("jal_count", 32'(o_ras_count), 32'd1);
    req(2'd3, 1'b1, 26'h0, 32'h0, 32'h100); step();
    chk("ret_hit",   32'(o_pred_hit), 32'd1);
    chk("ret_pred",  o_pred_target, 32'h100);
    chk("ret_count", 32'(o_ras_count), 32'd0);
    req(2'd1, 1'b0, 26'h0, 32'h100, 32'h0); step();
    req(2'd3, 1'b1, 26'h0, 32'h0, 32'h104); step();
    chk("miss_hit",    32'(o_pred_hit), 32'd0);
    chk("miss_pred",   o_pred_target, 32'h100);
    chk("miss_target", o_target, 32'h104);

    // Overflow: five pushes into four entries, then five pops
    for (int k = 1; k <= 5; k++) begin
      req(2'd1, 1'b0, 26'h0, 32'(k * 16), 32'h0); step();
    end
    chk("sat_count", 32'(o_ras_count), 32'd4);
    for (int k = 5; k >= 2; k--) begin
      req(2'd3, 1'b1, 26'h0, 32'h0, 32'(k * 16)); step();
      chk("pop_pred", o_pred_target, 32'(k * 16));
      chk("pop_hit",  32'(o_pred_hit), 32'd1);
    end
    req(2'd3, 1'b1, 26'h0, 32'h0, 32'h10); step();
    chk("empty_hit",   32'(o_pred_hit), 32'd0);
    chk("empty_pred",  o_pred_target, 32'd0);
    chk("empty_count", 32'(o_ras_count), 32'd0);
    chk("empty_valid", 32'(o_valid), 32'd1);

    // Stall and flush
    req(2'd1, 1'b0, 26'h0, 32'h200, 32'h0); step();
    chk("pre_stall_count", 32'(o_ras_count), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 26'h0, 32'h300, 32'h0); step();
    chk("stall_valid", 32'(o_valid), 32'd1);
    chk("stall_link",  o_link, 32'h200);
    chk("stall_count", 32'(o_ras_count), 32'd1);
    step();
    chk("stall2_valid", 32'(o_valid), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 26'h0, 32'h400, 32'h0); step();
    chk("flush_valid", 32'(o_valid), 32'd0);
    chk("flush_count", 32'(o_ras_count), 32'd1);

    // Asynchronous reset mid-cycle with three live entries
    req(2'd1, 1'b0, 26'h0, 32'h500, 32'h0); step();
    req(2'd1, 1'b0, 26'h0, 32'h600, 32'h0); step();
    chk("pre_rst_count", 32'(o_ras_count), 32'd3);
    chk("pre_rst_valid", 32'(o_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_count",  32'(o_ras_count), 32'd0);
    chk("arst_valid",  32'(o_valid), 32'd0);
    chk("arst_link",   o_link, 32'd0);
    chk("arst_target", o_target, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; v = 1'b0;
    step();
    chk("post_rst_count", 32'(o_ras_count), 32'd0);
    req(2'd1, 1'b0, 26'h0, 32'h700, 32'h0); step();
    chk("post_rst_push", 32'(o_ras_count), 32'd1);
    idle(); step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
